multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the RV64I-subset datapath: memory, register file, ALU and immediate generator.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath enable.
- Holds in FETCH/MEM until memory acknowledges; traps on unsupported opcodes.
- Counts retired instructions for bench and debug visibility.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- TIMEOUT_CYCLES, 16, max mem_ready wait cycles (used only with optional feature)

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- Opcode  in  7  Instruction[6:0] from instruction register; sampled in DECODE
- Zero  in  1  ALU zero flag, used in EXEC for BEQ
- mem_ready  in  1  memory ack; completes the current read/write this cycle
- PCWrite  out  1  PC <= PC+4
- PCWriteCond  out  1  PC <= branch target
- IRWrite  out  1  latch instruction register
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- RegWrite  out  1  register-file write
- MemtoReg  out  1  writeback source select: 1 = memory data
- ALUSrc  out  1  1 = immediate operand
- ALUOp  out  2  00 add, 01 sub, 10 R-funct, 11 I-funct
- state  out  3  current state encoding
- illegal  out  1  sticky trap flag
- retired  out  CNT_W  completed-instruction count

Behaviour:
- Reset: on a clk edge with reset=1, the block sets state=FETCH(000), clears the latched opcode, illegal=0 and retired=0.
- Output gating: while reset=1, every control output is forced to 0 combinationally.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to FETCH on the next edge.
- Supported opcodes (latched in DECODE, the "current opcode" below):
  - R = 0110011
  - I-ALU = 0010011
  - LD = 0000011
  - SD = 0100011
  - BEQ = 1100011
- FETCH:
  - MemRead=1 throughout.
  - If mem_ready=0: IRWrite=0, PCWrite=0, stay in FETCH.
  - If mem_ready=1: IRWrite=1 and PCWrite=1 (combinational), go to DECODE.
- DECODE:
  - All enables 0; latch Opcode.
  - Supported opcode: go to EXEC. Otherwise: go to TRAP.
- EXEC:
  - R: ALUOp=10, ALUSrc=0, go to WB.
  - I-ALU: ALUOp=11, ALUSrc=1, go to WB.
  - LD/SD: ALUOp=00, ALUSrc=1, go to MEM.
  - BEQ: ALUOp=01, ALUSrc=0, PCWriteCond=Zero, go to FETCH; retired increments on this edge.
- MEM:
  - LD: MemRead=1. When mem_ready=1, go to WB.
  - SD: MemWrite=1. When mem_ready=1, go to FETCH and retired increments.
  - Stay in MEM while mem_ready=0.
- WB:
  - RegWrite=1 for exactly one cycle; MemtoReg=1 only for LD.
  - Go to FETCH; retired increments.
- TRAP:
  - illegal=1; all other enables 0.
  - Stays in TRAP until reset.
- Fixed latencies with mem_ready always 1: R/I = 4 cycles, LD = 5, SD = 4, BEQ = 3.
- Counter: retired wraps modulo 2^CNT_W with no saturation.
- Reset mid-instruction: reset has priority on every edge. Any pending MemWrite is dropped, and the next cycle after reset deasserts is FETCH.
- mem_ready outside FETCH/MEM is ignored.

Optional Feature:
- Macro: MEMCTRL_TIMEOUT_EN.
- Defined:
  - A wait counter of clog2(TIMEOUT_CYCLES+1) bits increments each cycle spent in FETCH or MEM with mem_ready=0.
  - The counter clears on state change or on mem_ready=1.
  - On reaching TIMEOUT_CYCLES, the FSM goes to TRAP and sets illegal=1.
  - An extra output `timeout` (1 bit, sticky until reset) is added.
- Undefined: no counter, no `timeout` port; the FSM waits indefinitely.

Test Plan:
- reset=1 for 2 cycles, then release with mem_ready=1, Opcode=0110011 -> state sequence 0,1,2,4,0; RegWrite high only in state 4; ALUOp=10 in EXEC; retired=1.
- LD (0000011), mem_ready low for 3 cycles in MEM -> MemRead held 4 cycles in MEM; WB has MemtoReg=1, RegWrite=1; retired=1.
- BEQ (1100011) with Zero=1, then BEQ with Zero=0 -> PCWriteCond=1 then 0 in EXEC; 3 cycles each; retired=2.
- Opcode=1111111 in DECODE -> state=5, illegal=1 held 20 cycles; reset -> state=0, illegal=0, retired=0.
- SD with mem_ready=0 in MEM, reset asserted on MEM cycle 2 -> MemWrite=0 while reset=1; state=0 after release; retired unchanged at 0.
- MEMCTRL_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, mem_ready stuck 0 in FETCH -> TRAP after 4 waiting cycles; timeout=1, illegal=1.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle sequencer and its datapath.
// The timeout status line exists only when MEMCTRL_TIMEOUT_EN is defined.
interface multicycle_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       Opcode;
   logic             Zero;
   logic             mem_ready;
   logic             PCWrite;
   logic             PCWriteCond;
   logic             IRWrite;
   logic             MemRead;
   logic             MemWrite;
   logic             RegWrite;
   logic             MemtoReg;
   logic             ALUSrc;
   logic [1:0]       ALUOp;
   logic [2:0]       state;
   logic             illegal;
   logic [CNT_W-1:0] retired;
`ifdef MEMCTRL_TIMEOUT_EN
   logic             timeout;

   modport master (
      input  Opcode, Zero, mem_ready,
      output PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite,
             MemtoReg, ALUSrc, ALUOp, state, illegal, retired, timeout
   );
   modport slave (
      output Opcode, Zero, mem_ready,
      input  PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite,
             MemtoReg, ALUSrc, ALUOp, state, illegal, retired, timeout
   );
`else
   modport master (
      input  Opcode, Zero, mem_ready,
      output PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite,
             MemtoReg, ALUSrc, ALUOp, state, illegal, retired
   );
   modport slave (
      output Opcode, Zero, mem_ready,
      input  PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite,
             MemtoReg, ALUSrc, ALUOp, state, illegal, retired
   );
`endif
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64I-subset multi-cycle datapath.
// Optional memory-wait watchdog enabled by defining MEMCTRL_TIMEOUT_EN.
module multicycle_ctrl_fsm #(
   parameter int CNT_W          = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                clk,
   input logic                reset,
   multicycle_ctrl_if.master  bus
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   state_t           state_q;
   logic [6:0]       op_q;
   logic             illegal_q;
   logic [CNT_W-1:0] retired_q;

   logic             pc_write;
   logic             pc_write_cond;
   logic             ir_write;
   logic             mem_read;
   logic             mem_write;
   logic             reg_write;
   logic             mem_to_reg;
   logic             alu_src;
   logic [1:0]       alu_op;

   function automatic logic supported(input logic [6:0] op);
      return op inside {OP_R, OP_I, OP_LD, OP_SD, OP_BEQ};
   endfunction

`ifdef MEMCTRL_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WAIT_W-1:0] wait_q;
   logic              timeout_q;
   logic              waiting;
   logic              expired;

   assign waiting = ((state_q == FETCH) || (state_q == MEM)) && !bus.mem_ready;
   // This edge would be the TIMEOUT_CYCLES-th consecutive stalled cycle.
   assign expired = waiting && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
   assign bus.timeout = timeout_q;
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         op_q      <= '0;
         illegal_q <= 1'b0;
         retired_q <= '0;
`ifdef MEMCTRL_TIMEOUT_EN
         wait_q    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            FETCH: if (bus.mem_ready) state_q <= DECODE;
            DECODE: begin
               op_q <= bus.Opcode;
               if (supported(bus.Opcode)) begin
                  state_q <= EXEC;
               end else begin
                  state_q   <= TRAP;
                  illegal_q <= 1'b1;
               end
            end
            EXEC: begin
               case (op_q)
                  OP_R, OP_I:   state_q <= WB;
                  OP_LD, OP_SD: state_q <= MEM;
                  OP_BEQ: begin
                     state_q   <= FETCH;
                     retired_q <= retired_q + CNT_W'(1);
                  end
                  default: begin
                     state_q   <= TRAP;
                     illegal_q <= 1'b1;
                  end
               endcase
            end
            MEM: begin
               if (bus.mem_ready) begin
                  if (op_q == OP_LD) begin
                     state_q <= WB;
                  end else begin
                     state_q   <= FETCH;
                     retired_q <= retired_q + CNT_W'(1);
                  end
               end
            end
            WB: begin
               state_q   <= FETCH;
               retired_q <= retired_q + CNT_W'(1);
            end
            TRAP:    illegal_q <= 1'b1;
            default: state_q <= FETCH;
         endcase
`ifdef MEMCTRL_TIMEOUT_EN
         // Watchdog overrides whatever the case above chose.
         if (expired) begin
            state_q   <= TRAP;
            illegal_q <= 1'b1;
            timeout_q <= 1'b1;
            wait_q    <= '0;
         end else if (waiting) begin
            wait_q <= wait_q + 1'b1;
         end else begin
            wait_q <= '0;
         end
`endif
      end
   end

   // Enables decode from the registered state; mem_ready/Zero pass through
   // combinationally so the datapath acts in the same cycle as the ack.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src       = 1'b0;
      alu_op        = 2'b00;
      if (!reset) begin
         case (state_q)
            FETCH: begin
               mem_read = 1'b1;
               ir_write = bus.mem_ready;
               pc_write = bus.mem_ready;
            end
            EXEC: begin
               case (op_q)
                  OP_R:   alu_op = 2'b10;
                  OP_I: begin
                     alu_op  = 2'b11;
                     alu_src = 1'b1;
                  end
                  OP_LD, OP_SD: begin
                     alu_op  = 2'b00;
                     alu_src = 1'b1;
                  end
                  OP_BEQ: begin
                     alu_op        = 2'b01;
                     pc_write_cond = bus.Zero;
                  end
                  default: ;
               endcase
            end
            MEM: begin
               mem_read  = (op_q == OP_LD);
               mem_write = (op_q == OP_SD);
            end
            WB: begin
               reg_write  = 1'b1;
               mem_to_reg = (op_q == OP_LD);
            end
            default: ;
         endcase
      end
   end

   assign bus.PCWrite     = pc_write;
   assign bus.PCWriteCond = pc_write_cond;
   assign bus.IRWrite     = ir_write;
   assign bus.MemRead     = mem_read;
   assign bus.MemWrite    = mem_write;
   assign bus.RegWrite    = reg_write;
   assign bus.MemtoReg    = mem_to_reg;
   assign bus.ALUSrc      = alu_src;
   assign bus.ALUOp       = alu_op;
   assign bus.state       = state_q;
   assign bus.illegal     = illegal_q;
   assign bus.retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: directed scenarios with literal
// expectations plus a randomized run against an instruction-level model.
module tb_multicycle_ctrl_fsm;
   localparam int CNT_W = 4;
`ifdef MEMCTRL_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 16;
`endif
   localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD_OP = 7'b0000011;
   localparam logic [6:0] SD_OP = 7'b0100011, BEQ_OP = 7'b1100011;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multicycle_ctrl_if #(.CNT_W(CNT_W)) bus();

   multicycle_ctrl_fsm #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Tracks which step of which instruction class is active, in the spec's
   // state numbering, plus the retired tally and sticky flags.
   bit armed = 0;
   int m_st, m_ret, m_wait;
   logic [6:0] m_op;
   bit m_ill, m_to;

   function automatic bit is_supported(input logic [6:0] op);
      return (op == R_OP) || (op == I_OP) || (op == LD_OP) || (op == SD_OP) || (op == BEQ_OP);
   endfunction

   always @(posedge clk) begin
      int nst;
      if (reset) begin
         armed = 1; m_st = 0; m_op = '0; m_ill = 0; m_ret = 0; m_wait = 0; m_to = 0;
      end else if (armed) begin
         nst = m_st;
         if (m_st == 0) nst = bus.mem_ready ? 1 : 0;
         else if (m_st == 1) begin
            m_op = bus.Opcode;
            if (is_supported(bus.Opcode)) nst = 2;
            else begin nst = 5; m_ill = 1; end
         end else if (m_st == 2) begin
            if (m_op == BEQ_OP) begin nst = 0; m_ret++; end
            else nst = (m_op == LD_OP || m_op == SD_OP) ? 3 : 4;
         end else if (m_st == 3) begin
            if (bus.mem_ready) begin
               if (m_op == LD_OP) nst = 4;
               else begin nst = 0; m_ret++; end
            end
         end else if (m_st == 4) begin nst = 0; m_ret++; end
         else if (m_st != 5) nst = 0;
`ifdef MEMCTRL_TIMEOUT_EN
         if ((m_st == 0 || m_st == 3) && !bus.mem_ready) begin
            m_wait++;
            if (m_wait == TO) begin nst = 5; m_ill = 1; m_to = 1; m_wait = 0; end
         end else m_wait = 0;
`endif
         m_st = nst;
      end
   end

   function automatic logic [9:0] exp_en(input int st, input logic [6:0] op,
                                         input logic rdy, input logic z);
      logic pcw, pcwc, irw, mr, mw, rw, m2r, src;
      logic [1:0] aop;
      {pcw, pcwc, irw, mr, mw, rw, m2r, src, aop} = '0;
      if (st == 0) begin mr = 1; irw = rdy; pcw = rdy; end
      if (st == 2) begin
         if (op == R_OP) aop = 2'b10;
         if (op == I_OP) begin aop = 2'b11; src = 1; end
         if (op == LD_OP || op == SD_OP) begin aop = 2'b00; src = 1; end
         if (op == BEQ_OP) begin aop = 2'b01; pcwc = z; end
      end
      if (st == 3) begin mr = (op == LD_OP); mw = (op == SD_OP); end
      if (st == 4) begin rw = 1; m2r = (op == LD_OP); end
      return {pcw, pcwc, irw, mr, mw, rw, m2r, src, aop};
   endfunction

   wire [9:0] dut_en = {bus.PCWrite, bus.PCWriteCond, bus.IRWrite, bus.MemRead, bus.MemWrite,
                        bus.RegWrite, bus.MemtoReg, bus.ALUSrc, bus.ALUOp};

   always @(negedge clk) begin
      if (armed) begin
         if (reset) begin
            chk("gated_enables", 64'(dut_en), 64'd0);
         end else begin
            chk("enables", 64'(dut_en), 64'(exp_en(m_st, m_op, bus.mem_ready, bus.Zero)));
            chk("state", 64'(bus.state), 64'(m_st));
            chk("illegal", 64'(bus.illegal), 64'(m_ill));
            chk("retired", 64'(bus.retired), 64'(m_ret & ((1 << CNT_W) - 1)));
`ifdef MEMCTRL_TIMEOUT_EN
            chk("timeout", 64'(bus.timeout), 64'(m_to));
`endif
         end
      end
   end

   // ---------------- directed helpers ----------------
   logic [2:0]       r_st   [32];
   logic             r_mr   [32];
   logic             r_mw   [32];
   logic             r_rw   [32];
   logic             r_m2r  [32];
   logic             r_pcwc [32];
   logic [1:0]       r_aop  [32];
   logic             r_ill  [32];
   logic [CNT_W-1:0] r_ret  [32];

   // Called just after a rising edge; cycle i uses ready/zero bit i.
   task automatic run(input int n, input logic [31:0] rmask, input logic [31:0] zmask);
      for (int i = 0; i < n; i++) begin
         bus.mem_ready = rmask[i];
         bus.Zero      = zmask[i];
         @(negedge clk);
         r_st[i] = bus.state;  r_mr[i] = bus.MemRead;   r_mw[i] = bus.MemWrite;
         r_rw[i] = bus.RegWrite; r_m2r[i] = bus.MemtoReg; r_pcwc[i] = bus.PCWriteCond;
         r_aop[i] = bus.ALUOp; r_ill[i] = bus.illegal; r_ret[i] = bus.retired;
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      int exp_r[5];
      int cnt;
      logic [6:0] ops[5];
      exp_r = '{0, 1, 2, 4, 0};
      ops   = '{R_OP, I_OP, LD_OP, SD_OP, BEQ_OP};
      reset = 1'b1; bus.Opcode = R_OP; bus.Zero = 1'b0; bus.mem_ready = 1'b1;

      // R-type after a two-cycle reset
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      run(5, 32'hFFFF_FFFF, 32'h0);
      for (int i = 0; i < 5; i++) begin
         chk("r_state_seq", 64'(r_st[i]), 64'(exp_r[i]));
         chk("r_regwrite", 64'(r_rw[i]), 64'(i == 3));
      end
      chk("r_aluop_exec", 64'(r_aop[2]), 64'd2);
      chk("r_retired", 64'(r_ret[4]), 64'd1);

      // LD with three stalled MEM cycles
      do_reset(); bus.Opcode = LD_OP;
      run(9, 32'h1C7, 32'h0);
      cnt = 0;
      for (int i = 0; i < 9; i++) if (r_st[i] == 3 && r_mr[i]) cnt++;
      chk("ld_memread_cycles", 64'(cnt), 64'd4);
      chk("ld_wb_state", 64'(r_st[7]), 64'd4);
      chk("ld_wb_memtoreg", 64'(r_m2r[7]), 64'd1);
      chk("ld_wb_regwrite", 64'(r_rw[7]), 64'd1);
      chk("ld_retired", 64'(r_ret[8]), 64'd1);

      // Two back-to-back BEQs, taken then not taken
      do_reset(); bus.Opcode = BEQ_OP;
      run(7, 32'hFFFF_FFFF, 32'h4);
      chk("beq1_pcwritecond", 64'(r_pcwc[2]), 64'd1);
      chk("beq1_aluop", 64'(r_aop[2]), 64'd1);
      chk("beq1_done_fetch", 64'(r_st[3]), 64'd0);
      chk("beq2_pcwritecond", 64'(r_pcwc[5]), 64'd0);
      chk("beq2_done_fetch", 64'(r_st[6]), 64'd0);
      chk("beq_retired", 64'(r_ret[6]), 64'd2);

      // Unsupported opcode traps and holds until reset
      do_reset(); bus.Opcode = 7'b1111111;
      run(22, 32'hFFFF_FFFF, 32'h0);
      cnt = 0;
      for (int i = 2; i < 22; i++) if (r_st[i] == 5 && r_ill[i]) cnt++;
      chk("trap_hold_cycles", 64'(cnt), 64'd20);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; bus.Opcode = R_OP;
      @(negedge clk);
      chk("trap_reset_state", 64'(bus.state), 64'd0);
      chk("trap_reset_illegal", 64'(bus.illegal), 64'd0);
      chk("trap_reset_retired", 64'(bus.retired), 64'd0);
      @(posedge clk); #1;

      // SD stalled in MEM, reset arrives on the second MEM cycle
      do_reset(); bus.Opcode = SD_OP;
      run(4, 32'h7, 32'h0);
      chk("sd_memwrite_mem1", 64'(r_mw[3]), 64'd1);
      reset = 1'b1; bus.mem_ready = 1'b0;
      @(negedge clk);
      chk("sd_memwrite_in_reset", 64'(bus.MemWrite), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("sd_after_reset_state", 64'(bus.state), 64'd0);
      chk("sd_after_reset_retired", 64'(bus.retired), 64'd0);
      chk("sd_after_reset_memwrite", 64'(bus.MemWrite), 64'd0);
      @(posedge clk); #1;

      // Memory never answers in FETCH
      do_reset(); bus.Opcode = R_OP;
`ifdef MEMCTRL_TIMEOUT_EN
      run(6, 32'h0, 32'h0);
      chk("to_still_waiting", 64'(r_st[3]), 64'd0);
      chk("to_trap_state", 64'(r_st[4]), 64'd5);
      chk("to_timeout_flag", 64'(bus.timeout), 64'd1);
      chk("to_illegal_flag", 64'(bus.illegal), 64'd1);
`else
      run(20, 32'h0, 32'h0);
      chk("stall_fetch_state", 64'(r_st[19]), 64'd0);
      chk("stall_illegal", 64'(r_ill[19]), 64'd0);
`endif

      // Randomized traffic, including stalls, traps, mid-instruction resets
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset         = ($urandom_range(0, 199) == 0);
         bus.mem_ready = ($urandom_range(0, 3) != 0);
         bus.Zero      = 1'($urandom_range(0, 1));
         bus.Opcode    = ($urandom_range(0, 39) == 0) ? 7'($urandom) : ops[$urandom_range(0, 4)];
         @(posedge clk); #1;
      end
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
